// File: rtl/nf_10g_pkg.sv
// Shared constants and read-FSM encoding for the 10G TX datapath blocks.
// Default AXIS width / buffer depth live here so every user agrees on them.
package nf_10g_pkg;

    localparam int NF_AXIS_DATA_WIDTH = 64;
    localparam int NF_DEPTH_LOG2      = 9;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_LOAD = 2'd1,
        RD_SEND = 2'd2
    } rd_state_e;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/nf_10g_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A read that hits the address being written returns the new word.
module nf_10g_sdp_ram #(
    parameter int DW = 73,
    parameter int AW = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass matters when the reader fetches a 1-beat frame committed this very cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/nf_10g_tx_store_fwd.sv
// Store-and-forward TX buffer: a frame is released to the MAC only once fully stored.
// Define NF_10G_TX_STORE_FWD_DROP_CNT_EN to build the saturating oversize-drop counter.
module nf_10g_tx_store_fwd
    import nf_10g_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = NF_AXIS_DATA_WIDTH,
    parameter int C_DEPTH_LOG2      = NF_DEPTH_LOG2
) (
    input  logic                           clk156,
    input  logic                           areset_clk156,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    input  logic                           m_axis_tready,
    output logic [31:0]                    drop_count,
    output rd_state_e                      dbg_rd_state,
    output logic [C_DEPTH_LOG2:0]          dbg_frames_stored
);

    localparam int KW   = keep_width(C_AXIS_DATA_WIDTH);
    localparam int RW   = C_AXIS_DATA_WIDTH + KW + 1;
    localparam int FS_W = C_DEPTH_LOG2 + 1;

    typedef logic [C_DEPTH_LOG2-1:0] ptr_t;

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             wr_commit_q, wr_commit_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [FS_W-1:0]  frames_stored_q, frames_stored_d;
    logic             dropping_q, dropping_d;
    logic             ready_en_q;
    rd_state_e        state_q, state_d;
    logic             m_valid_q, m_valid_d;

    logic             full;
    logic             s_hs;
    logic             wr_en;
    logic             commit;
    logic             m_hs;
    logic             m_last_hs;
    logic             ram_re;
    logic [RW-1:0]    ram_rdata;

    // Both ports: a beat transfers on a clock edge where valid && ready; the
    // source holds valid and payload steady until then, ready may move freely.
    assign full          = (wr_ptr_q + ptr_t'(1)) == rd_ptr_q;
    assign s_axis_tready = ready_en_q && (!full || dropping_q);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign wr_en         = s_hs && !dropping_q;
    assign commit        = wr_en && s_axis_tlast;
    assign m_hs          = m_valid_q && m_axis_tready;
    assign m_last_hs     = m_hs && m_axis_tlast;

    assign frames_stored_d = frames_stored_q + FS_W'(commit) - FS_W'(m_last_hs);

    nf_10g_sdp_ram #(
        .DW (RW),
        .AW (C_DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk156),
        .rst_i   (areset_clk156),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // Write side. A frame that fills the buffer with nothing committed can never
    // fit, so the rest of it is swallowed and the write pointer rewound.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        dropping_d  = dropping_q;
        if (dropping_q) begin
            if (s_hs && s_axis_tlast) begin
                dropping_d = 1'b0;
                wr_ptr_d   = wr_commit_q;
            end
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (commit) begin
                wr_commit_d = wr_ptr_q + ptr_t'(1);
            end
            if (full && (frames_stored_q == '0) && (wr_ptr_q != wr_commit_q)) begin
                dropping_d = 1'b1;
            end
        end
    end

    // Read side. rd_ptr_q always addresses the next beat to fetch; the beat on
    // m_axis sits in the RAM output register, which only advances on a fetch.
    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        rd_ptr_d  = rd_ptr_q;
        ram_re    = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (frames_stored_q != '0) begin
                    state_d = RD_LOAD;
                end
            end
            RD_LOAD: begin
                ram_re    = 1'b1;
                rd_ptr_d  = rd_ptr_q + ptr_t'(1);
                m_valid_d = 1'b1;
                state_d   = RD_SEND;
            end
            RD_SEND: begin
                if (m_hs) begin
                    if (m_axis_tlast && (frames_stored_d == '0)) begin
                        m_valid_d = 1'b0;
                        state_d   = RD_IDLE;
                    end else begin
                        ram_re   = 1'b1;
                        rd_ptr_d = rd_ptr_q + ptr_t'(1);
                    end
                end
            end
            default: begin
                state_d   = RD_IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk156 or posedge areset_clk156) begin
        if (areset_clk156) begin
            wr_ptr_q        <= '0;
            wr_commit_q     <= '0;
            rd_ptr_q        <= '0;
            frames_stored_q <= '0;
            dropping_q      <= 1'b0;
            ready_en_q      <= 1'b0;
            state_q         <= RD_IDLE;
            m_valid_q       <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            wr_commit_q     <= wr_commit_d;
            rd_ptr_q        <= rd_ptr_d;
            frames_stored_q <= frames_stored_d;
            dropping_q      <= dropping_d;
            ready_en_q      <= 1'b1;
            state_q         <= state_d;
            m_valid_q       <= m_valid_d;
        end
    end

`ifdef NF_10G_TX_STORE_FWD_DROP_CNT_EN
    logic [31:0] drop_cnt_q;

    always_ff @(posedge clk156 or posedge areset_clk156) begin
        if (areset_clk156) begin
            drop_cnt_q <= '0;
        end else if (dropping_q && !dropping_d && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

    assign m_axis_tvalid     = m_valid_q;
    assign m_axis_tdata      = ram_rdata[C_AXIS_DATA_WIDTH-1:0];
    assign m_axis_tkeep      = ram_rdata[C_AXIS_DATA_WIDTH +: KW];
    assign m_axis_tlast      = ram_rdata[RW-1];
    assign m_axis_tuser      = 1'b0;
    assign dbg_rd_state      = state_q;
    assign dbg_frames_stored = frames_stored_q;

endmodule

// File: tb/tb_nf_10g_tx_store_fwd.sv
// Bench for nf_10g_tx_store_fwd: frame-level reference model and scoreboard, vector
// table plus hand-written latency, backpressure, wrap and reset sequences.
module tb_nf_10g_tx_store_fwd;
  import nf_10g_pkg::*;

  localparam int DEPTH   = 512;
  localparam int BW      = 73;
  localparam int TIMEOUT = 20000;

  logic        clk;
  logic        rst;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_valid;
  logic        m_last;
  logic        m_user;
  logic        m_ready;
  logic [31:0] drop_count;
  rd_state_e   dbg_state;
  logic [9:0]  dbg_fs;

  nf_10g_tx_store_fwd dut (
    .clk156            (clk),
    .areset_clk156     (rst),
    .s_axis_tdata      (s_data),
    .s_axis_tkeep      (s_keep),
    .s_axis_tvalid     (s_valid),
    .s_axis_tlast      (s_last),
    .s_axis_tready     (s_ready),
    .m_axis_tdata      (m_data),
    .m_axis_tkeep      (m_keep),
    .m_axis_tvalid     (m_valid),
    .m_axis_tlast      (m_last),
    .m_axis_tuser      (m_user),
    .m_axis_tready     (m_ready),
    .drop_count        (drop_count),
    .dbg_rd_state      (dbg_state),
    .dbg_frames_stored (dbg_fs)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // output ready pattern: 0 = stalled, 1 = always ready, 2 = random 50%
  int m_ready_mode = 0;
  initial m_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    case (m_ready_mode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // scoreboard state
  int n_checks = 0;
  int n_pass = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] cur_q[$];
  int model_fs = 0;
  int drops_exp = 0;
  int in_beats = 0;
  int out_beats = 0;
  int sim_cnt = 0;
  int sim_fs = 0;
  bit sim_pending = 0;
  bit prev_stall = 0;
  bit prev_valid = 0;
  bit out_in_frame = 0;
  logic [BW-1:0] prev_beat = '0;
  int tlast_edge = 0;
  int valid_rise_edge = 0;
  logic [7:0] last_out_keep = '0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // monitor + reference model, sampled mid-cycle
  always @(negedge clk) begin
    logic [BW-1:0] e;
    logic [BW-1:0] act;
    bit out_last;
    int fs_before;
    if (rst) begin
      exp_q.delete();
      cur_q.delete();
      model_fs = 0;
      drops_exp = 0;
      sim_pending = 0;
      prev_stall = 0;
      prev_valid = 0;
      out_in_frame = 0;
    end else begin
      act = {m_last, m_keep, m_data};
      fs_before = model_fs;
      chk(dbg_fs == 10'(model_fs), "frames_stored", dbg_fs, model_fs);
      if (sim_pending) begin
        chk(dbg_fs == 10'(sim_fs), "simul_fs_unchanged", dbg_fs, sim_fs);
        sim_pending = 0;
      end
      if (prev_stall || out_in_frame) chk(m_valid == 1'b1, "tvalid_held", m_valid, 1);
      if (prev_stall && m_valid) chk(act == prev_beat, "hold_stable", act, prev_beat);
      if (m_valid && !prev_valid) valid_rise_edge = cyc;
      out_last = 0;
      if (m_valid && m_ready) begin
        out_beats++;
        chk(m_user == 1'b0, "tuser", m_user, 0);
        chk(exp_q.size() != 0, "beat_expected", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(act == e, "out_beat", act, e);
          out_last = e[BW-1];
          if (out_last) begin
            model_fs--;
            last_out_keep = m_keep;
          end
        end else begin
          out_last = m_last;
        end
        out_in_frame = !out_last;
      end
      if (s_valid && s_ready) begin
        in_beats++;
        cur_q.push_back({s_last, s_keep, s_data});
        if (s_last) begin
          tlast_edge = cyc + 1;
          if (cur_q.size() > DEPTH - 1) begin
            drops_exp++;
          end else begin
            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
            model_fs++;
            if (out_last) begin
              sim_cnt++;
              sim_pending = 1;
              sim_fs = fs_before;
            end
          end
          cur_q.delete();
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_beat = act;
      prev_valid = m_valid;
    end
  end

  // driver tasks (called at posedge+1)
  task automatic wait_accept();
    int t = 0;
    bit acc = 0;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      t++;
      if (t > TIMEOUT) begin
        chk(0, "accept_timeout", t, TIMEOUT);
        finish_run();
      end
    end
  endtask

  task automatic drive_beat(input bit last, input logic [7:0] keep);
    s_data = {$urandom(), $urandom()};
    s_keep = keep;
    s_last = last;
    s_valid = 1'b1;
  endtask

  task automatic send_frame(input int len, input logic [7:0] last_keep, input int gap);
    for (int i = 0; i < len; i++) begin
      drive_beat(i == len - 1, (i == len - 1) ? last_keep : 8'($urandom_range(0, 255)));
      wait_accept();
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 || m_valid || model_fs != 0) begin
      @(negedge clk);
      t++;
      if (t > TIMEOUT) begin
        chk(0, "drain_timeout", exp_q.size(), 0);
        finish_run();
      end
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         len;
    logic [7:0] last_keep;
    int         mode;
    int         exp_beats;
    int         exp_drop;
    bit         chk_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ob;
    int ib;
    int sc;
    int vcnt;
    logic [31:0] dc;
    int exp_dc;
    vecs[0] = '{8,   8'h0F, 1, 8,   0, 1};
    vecs[1] = '{1,   8'h01, 1, 1,   0, 1};
    vecs[2] = '{600, 8'hFF, 1, 0,   1, 0};
    vecs[3] = '{4,   8'h3F, 1, 4,   0, 1};
    vecs[4] = '{511, 8'h7F, 2, 511, 0, 0};
    vecs[5] = '{512, 8'hFF, 1, 0,   1, 0};
    vecs[6] = '{17,  8'h80, 2, 17,  0, 0};

    rst = 1'b1;
    s_data = '0;
    s_keep = '0;
    s_valid = 1'b0;
    s_last = 1'b0;

    // reset state
    #12;
    chk(s_ready == 1'b0, "rst_tready", s_ready, 0);
    chk(m_valid == 1'b0, "rst_tvalid", m_valid, 0);
    chk(m_last == 1'b0, "rst_tlast", m_last, 0);
    chk(m_data == 64'h0, "rst_tdata", m_data, 0);
    chk(m_keep == 8'h0, "rst_tkeep", m_keep, 0);
    chk(m_user == 1'b0, "rst_tuser", m_user, 0);
    chk(drop_count == 32'h0, "rst_drop_count", drop_count, 0);
    chk(dbg_fs == 10'h0, "rst_frames_stored", dbg_fs, 0);
    chk(dbg_state == RD_IDLE, "rst_state", dbg_state, RD_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk(s_ready == 1'b0, "tready_before_edge", s_ready, 0);
    @(negedge clk);
    chk(s_ready == 1'b1, "tready_after_edge", s_ready, 1);
    @(posedge clk);
    #1;

    // vector table: single frames, latency, keep pass-through, oversize drop
    foreach (vecs[i]) begin
      m_ready_mode = vecs[i].mode;
      ob = out_beats;
      dc = drop_count;
      send_frame(vecs[i].len, vecs[i].last_keep, 0);
      wait_drain();
      chk(out_beats - ob == vecs[i].exp_beats, "vec_beats", out_beats - ob, vecs[i].exp_beats);
      exp_dc = vecs[i].exp_drop;
`ifndef NF_10G_TX_STORE_FWD_DROP_CNT_EN
      exp_dc = 0;
`endif
      chk(drop_count - dc == 32'(exp_dc), "vec_drop_count", drop_count - dc, exp_dc);
      if (vecs[i].exp_beats > 0)
        chk(last_out_keep == vecs[i].last_keep, "vec_last_keep", last_out_keep, vecs[i].last_keep);
      if (vecs[i].chk_lat)
        chk(valid_rise_edge - tlast_edge == 2, "latency", valid_rise_edge - tlast_edge, 2);
    end

    // back-to-back frames under random output backpressure
    m_ready_mode = 2;
    ob = out_beats;
    for (int f = 0; f < 3; f++) send_frame(8, 8'hFF, 0);
    wait_drain();
    chk(out_beats - ob == 24, "b2b_beats", out_beats - ob, 24);
    chk(dbg_fs == 10'h0, "b2b_fs_zero", dbg_fs, 0);
    chk(dbg_state == RD_IDLE, "b2b_idle", dbg_state, RD_IDLE);

    // backpressure: stalled output, 512 beats of 8-beat frames fill the buffer
    m_ready_mode = 0;
    ob = out_beats;
    ib = in_beats;
    dc = drop_count;
    for (int f = 0; f < 64; f++) send_frame(8, 8'($urandom_range(1, 255)), 0);
    repeat (4) @(negedge clk);
    chk(in_beats - ib == 512, "bp_beats_in", in_beats - ib, 512);
    chk(s_ready == 1'b0, "bp_tready_full", s_ready, 0);
    chk(dbg_fs == 10'd64, "bp_frames_stored", dbg_fs, 64);
    chk(drop_count == dc, "bp_no_drop", drop_count, dc);
    @(posedge clk);
    #1;
    m_ready_mode = 1;
    wait_drain();
    chk(out_beats - ob == 512, "bp_beats_out", out_beats - ob, 512);

    // wrap + same-cycle commit and output tlast
    m_ready_mode = 1;
    sc = sim_cnt;
    ob = out_beats;
    for (int f = 0; f < 70; f++) send_frame(8, 8'($urandom_range(1, 255)), 1);
    wait_drain();
    chk(out_beats - ob == 560, "wrap_beats", out_beats - ob, 560);
    chk(sim_cnt > sc, "simul_seen", sim_cnt - sc, 1);

    // randomized traffic
    ob = out_beats;
    ib = in_beats;
    for (int f = 0; f < 40; f++) begin
      m_ready_mode = $urandom_range(1, 2);
      send_frame($urandom_range(1, 48), 8'($urandom_range(1, 255)), $urandom_range(0, 3));
    end
    wait_drain();
    chk(out_beats - ob == in_beats - ib, "rand_beats", out_beats - ob, in_beats - ib);
    exp_dc = drops_exp;
`ifndef NF_10G_TX_STORE_FWD_DROP_CNT_EN
    exp_dc = 0;
`endif
    chk(drop_count == 32'(exp_dc), "total_drop_count", drop_count, exp_dc);

    // reset mid-frame while a frame is waiting on m_axis
    m_ready_mode = 0;
    send_frame(4, 8'hFF, 3);
    chk(m_valid == 1'b1, "pre_rst_tvalid", m_valid, 1);
    for (int b = 0; b < 3; b++) begin
      drive_beat(1'b0, 8'hFF);
      wait_accept();
    end
    drive_beat(1'b0, 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    chk(m_valid == 1'b0, "rst_mid_tvalid", m_valid, 0);
    chk(m_last == 1'b0, "rst_mid_tlast", m_last, 0);
    chk(s_ready == 1'b0, "rst_mid_tready", s_ready, 0);
    chk(dbg_fs == 10'h0, "rst_mid_fs", dbg_fs, 0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk(s_ready == 1'b0, "rel_tready_before_edge", s_ready, 0);
    @(negedge clk);
    chk(s_ready == 1'b1, "rel_tready_after_edge", s_ready, 1);
    m_ready_mode = 1;
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid) vcnt++;
    end
    chk(vcnt == 0, "no_stale_beats", vcnt, 0);
    @(posedge clk);
    #1;
    ob = out_beats;
    send_frame(4, 8'h0F, 0);
    wait_drain();
    chk(out_beats - ob == 4, "post_rst_beats", out_beats - ob, 4);
    chk(drop_count == 32'h0, "post_rst_drop_count", drop_count, 0);

    finish_run();
  end

endmodule
